// File: rtl/result_check_pkg.sv
// Shared definitions for the write-bus result checker.
// State encoding and default symbol constants.
package result_check_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CHECK  = 2'b01,
      REPORT = 2'b10
   } state_t;

   localparam int unsigned DEF_TEST_PORT = 32'h0000_0040;
   localparam logic [31:0] DEF_BEGIN_SYM = 32'h0000_0932;
   localparam logic [31:0] DEF_END_SYM   = 32'h0000_0D5D;
   localparam int          DEF_CHECK_NUM = 51;

endpackage

// File: rtl/result_checker_expected_gen.sv
// Expected-value generator for the result checker.
// Pure combinational (idx, mode) -> expected data word.
module expected_gen
   import result_check_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                IDX_W     = 6,
   parameter int                CHECK_NUM = DEF_CHECK_NUM,
   parameter logic [DATA_W-1:0] BASE      = DATA_W'(1),
   parameter logic [DATA_W-1:0] STEP      = DATA_W'(1),
   parameter logic [DATA_W-1:0] END_SYM   = DEF_END_SYM
) (
   input  logic [IDX_W-1:0]  idx,
   input  logic              mode_q,
   output logic [DATA_W-1:0] expected
);

   localparam logic [DATA_W-1:0] LAST = DATA_W'(CHECK_NUM - 1);
   localparam logic [DATA_W-1:0] TOP  = DATA_W'(CHECK_NUM - 2);

   logic [DATA_W-1:0] idx_x;
   logic [DATA_W-1:0] ord;

   // Descending mode walks the same arithmetic series from the top down
   always_comb begin
      idx_x    = DATA_W'(idx);
      ord      = mode_q ? (TOP - idx_x) : idx_x;
      expected = BASE + ord * STEP;
      if (idx_x == LAST) begin
         expected = END_SYM;
      end
   end

endmodule

// File: rtl/result_checker.sv
// Snoops the data-memory write bus and checks the values written to
// the test port against a generated sequence, then reports.
module result_checker
   import result_check_pkg::*;
#(
   parameter int                ADDR_W    = 30,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] TEST_PORT = ADDR_W'(DEF_TEST_PORT),
   parameter logic [DATA_W-1:0] BEGIN_SYM = DEF_BEGIN_SYM,
   parameter logic [DATA_W-1:0] END_SYM   = DEF_END_SYM,
   parameter int                CHECK_NUM = DEF_CHECK_NUM,
   parameter int                IDX_W     = 6,
   parameter logic [DATA_W-1:0] BASE      = DATA_W'(1),
   parameter logic [DATA_W-1:0] STEP      = DATA_W'(1),
   parameter int                ERR_W     = 8,
   parameter int                DUR_W     = 16,
   parameter logic [DUR_W-1:0]  TIMEOUT   = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic              wen,
   input  logic              mode,
   output logic [ERR_W-1:0]  error_num,
   output logic [DUR_W-1:0]  duration,
   output logic              finish,
   output logic              pass,
   output logic              timed_out,
   output logic [IDX_W-1:0]  first_err_idx,
   output logic [DATA_W-1:0] first_err_data
);

   localparam logic [IDX_W-1:0] IDX_END = IDX_W'(CHECK_NUM);
   localparam logic [ERR_W-1:0] ERR_MAX = {{(ERR_W-1){1'b1}}, 1'b0};

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              mode_q;
   logic              wen_q;
   logic [DATA_W-1:0] expected;
   logic              port;
   logic              hit;
   logic              arm;
   logic              mismatch;

   expected_gen #(
      .DATA_W    (DATA_W),
      .IDX_W     (IDX_W),
      .CHECK_NUM (CHECK_NUM),
      .BASE      (BASE),
      .STEP      (STEP),
      .END_SYM   (END_SYM)
   ) u_gen (
      .idx      (idx),
      .mode_q   (mode_q),
      .expected (expected)
   );

   // A stalled store keeps wen high; only its rising edge is a new write
   assign port     = (addr == TEST_PORT);
   assign hit      = wen && !wen_q && port;
   assign arm      = wen && port && (data == BEGIN_SYM);
   assign mismatch = (data != expected);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         idx            <= '0;
         mode_q         <= 1'b0;
         wen_q          <= 1'b0;
         error_num      <= '1;
         duration       <= '0;
         timed_out      <= 1'b0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else begin
         wen_q <= wen;
         unique case (state)
            IDLE: begin
               if (arm) begin
                  state     <= CHECK;
                  error_num <= '0;
                  duration  <= '0;
                  idx       <= '0;
                  mode_q    <= mode;
               end
            end
            CHECK: begin
               if (duration != TIMEOUT && duration != '1) begin
                  duration <= duration + 1'b1;
               end
               if (idx == IDX_END) begin
                  state <= REPORT;
               end else if (hit) begin
                  idx <= idx + 1'b1;
                  if (mismatch) begin
                     if (error_num == '0) begin
                        first_err_idx  <= idx;
                        first_err_data <= data;
                     end
                     if (error_num != ERR_MAX) begin
                        error_num <= error_num + 1'b1;
                     end
                  end
               end
               if (duration == TIMEOUT) begin
                  state     <= REPORT;
                  timed_out <= 1'b1;
               end
            end
            REPORT: begin
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign finish = (state == REPORT);
   assign pass   = finish && (error_num == '0) && !timed_out;

`ifdef SIMULATION
   logic reported;

   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         reported <= 1'b0;
      end else if (finish && !reported) begin
         reported <= 1'b1;
         $display("result_checker: errors=%0d cycles=%0d pass=%0b timeout=%0b first_idx=%0d first_data=%h",
                  error_num, duration, pass, timed_out,
                  first_err_idx, first_err_data);
      end
   end
`endif

endmodule

// File: tb/tb_result_checker.sv
// Randomised scoreboard bench for result_checker: default instance
// plus a short-timeout instance sharing the same snooped bus.
module tb_result_checker;

   localparam int          CN    = 51;
   localparam int          BASEV = 1;
   localparam int          STEPV = 1;
   localparam int          TM    = 65535;
   localparam int          TT    = 100;
   localparam logic [29:0] TP    = 30'h40;
   localparam logic [31:0] BSYM  = 32'h0000_0932;
   localparam logic [31:0] ESYM  = 32'h0000_0D5D;

   typedef struct {
      int          err;
      int          dur;
      int          fin;
      int          fidx;
      bit          pass;
      bit          to;
      logic [31:0] fdat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_m;
   logic        rst_t;
   logic [29:0] addr;
   logic [31:0] data;
   logic        wen;
   logic        mode;

   logic [7:0]  err_m, err_t;
   logic [15:0] dur_m, dur_t;
   logic        fin_m, fin_t, pass_m, pass_t, to_m, to_t;
   logic [5:0]  fidx_m, fidx_t;
   logic [31:0] fdat_m, fdat_t;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q_m[$];
   exp_t q_t[$];
   exp_t last_exp;

   logic [31:0] pv[$];
   int          ph[$];
   int          pg[$];
   bit          pn[$];
   bit          pgl[$];

   result_checker dut_m (
      .clk            (clk),
      .rst            (rst_m),
      .addr           (addr),
      .data           (data),
      .wen            (wen),
      .mode           (mode),
      .error_num      (err_m),
      .duration       (dur_m),
      .finish         (fin_m),
      .pass           (pass_m),
      .timed_out      (to_m),
      .first_err_idx  (fidx_m),
      .first_err_data (fdat_m)
   );

   result_checker #(.TIMEOUT(16'd100)) dut_t (
      .clk            (clk),
      .rst            (rst_t),
      .addr           (addr),
      .data           (data),
      .wen            (wen),
      .mode           (mode),
      .error_num      (err_t),
      .duration       (dur_t),
      .finish         (fin_t),
      .pass           (pass_t),
      .timed_out      (to_t),
      .first_err_idx  (fidx_t),
      .first_err_data (fdat_t)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_exp(input int n, input bit md);
      if (n == CN - 1) return ESYM;
      if (md) return 32'(BASEV + (CN - 2 - n) * STEPV);
      return 32'(BASEV + n * STEPV);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  nm, act, act, expv, expv);
      end
   endtask

   task automatic take(input bit sel);
      exp_t        x;
      string       p;
      logic [7:0]  e;
      logic [15:0] d;
      logic        ps, to;
      logic [5:0]  fi;
      logic [31:0] fd;
      p = sel ? "t." : "m.";
      if ((sel ? q_t.size() : q_m.size()) == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %sunexpected_finish: got finish at cycle %0d, expected none",
                  p, cyc);
         return;
      end
      x  = sel ? q_t.pop_front() : q_m.pop_front();
      e  = sel ? err_t : err_m;
      d  = sel ? dur_t : dur_m;
      ps = sel ? pass_t : pass_m;
      to = sel ? to_t : to_m;
      fi = sel ? fidx_t : fidx_m;
      fd = sel ? fdat_t : fdat_m;
      chk({p, "finish_cycle"}, cyc, x.fin);
      chk({p, "error_num"}, e, x.err);
      chk({p, "duration"}, d, x.dur);
      chk({p, "pass"}, ps, x.pass);
      chk({p, "timed_out"}, to, x.to);
      chk({p, "first_err_idx"}, fi, x.fidx);
      chk({p, "first_err_data"}, fd, x.fdat);
   endtask

   logic fm_q = 1'b0;
   logic ft_q = 1'b0;

   always @(negedge clk) begin
      if (fin_m && !fm_q) take(1'b0);
      if (fin_t && !ft_q) take(1'b1);
      fm_q <= fin_m;
      ft_q <= fin_t;
   end

   task automatic chk_reset(input bit sel);
      string p;
      p = sel ? "rst_t." : "rst_m.";
      chk({p, "error_num"}, sel ? err_t : err_m, 8'hFF);
      chk({p, "duration"}, sel ? dur_t : dur_m, 0);
      chk({p, "finish"}, sel ? fin_t : fin_m, 0);
      chk({p, "pass"}, sel ? pass_t : pass_m, 0);
      chk({p, "timed_out"}, sel ? to_t : to_m, 0);
      chk({p, "first_err_idx"}, sel ? fidx_t : fidx_m, 0);
      chk({p, "first_err_data"}, sel ? fdat_t : fdat_m, 0);
   endtask

   task automatic plan_good(input bit md, input int hold, input bit rnd,
                            input int cnt);
      pv.delete();
      ph.delete();
      pg.delete();
      pn.delete();
      pgl.delete();
      for (int i = 0; i < cnt; i++) begin
         pv.push_back(ref_exp(i, md));
         ph.push_back(hold != 0 ? hold : int'($urandom_range(1, 3)));
         pg.push_back(rnd ? int'($urandom_range(0, 2)) : 0);
         pn.push_back(rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
         pgl.push_back(rnd ? ($urandom_range(0, 4) == 0) : 1'b0);
      end
   endtask

   // Predicts the report from the planned schedule, queues it, then plays it
   task automatic run(input bit sel, input bit md, input bit expect_fin);
      int   t, a_at, exit_t, exit_e, n, errs, tmo;
      int   acc_at[$];
      exp_t x;
      tmo = sel ? TT : TM;
      t = cyc;
      a_at = t + 1;
      t += 2;
      for (int i = 0; i < pv.size(); i++) begin
         if (pn[i]) t += 2;
         t += pg[i];
         acc_at.push_back(t + 1);
         t += ph[i] + 1;
      end
      exit_t = a_at + tmo + 1;
      exit_e = exit_t;
      n = 0;
      errs = 0;
      x.fidx = 0;
      x.fdat = '0;
      for (int i = 0; i < pv.size(); i++) begin
         if (n == CN || acc_at[i] > exit_e) break;
         if (pv[i] != ref_exp(n, md)) begin
            if (errs == 0) begin
               x.fidx = n;
               x.fdat = pv[i];
            end
            errs++;
         end
         n++;
         if (n == CN && acc_at[i] + 1 < exit_e) exit_e = acc_at[i] + 1;
      end
      x.err  = errs > 254 ? 254 : errs;
      x.to   = (exit_e == exit_t);
      x.dur  = (exit_e - a_at) > tmo ? tmo : exit_e - a_at;
      x.pass = (errs == 0) && !x.to;
      x.fin  = exit_e;
      if (expect_fin) begin
         if (sel) q_t.push_back(x);
         else q_m.push_back(x);
         last_exp = x;
      end
      mode = md;
      addr = TP;
      data = BSYM;
      wen  = 1'b1;
      @(negedge clk);
      wen  = 1'b0;
      mode = 1'($urandom);
      @(negedge clk);
      for (int i = 0; i < pv.size(); i++) begin
         if (pn[i]) begin
            addr = TP ^ 30'($urandom_range(1, 255));
            data = $urandom;
            wen  = 1'b1;
            @(negedge clk);
            wen  = 1'b0;
            @(negedge clk);
         end
         repeat (pg[i]) begin
            addr = 30'($urandom);
            @(negedge clk);
         end
         addr = TP;
         for (int k = 0; k < ph[i]; k++) begin
            data = (pgl[i] && k == 1) ? (pv[i] ^ 32'hFFFF_0000) : pv[i];
            wen  = 1'b1;
            @(negedge clk);
         end
         wen = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic drain;
      for (int k = 0; k < 400; k++) begin
         if (q_m.size() == 0 && q_t.size() == 0) break;
         @(negedge clk);
      end
      if (q_m.size() + q_t.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL finish_wait: got %0d reports still pending, expected 0",
                  q_m.size() + q_t.size());
         q_m.delete();
         q_t.delete();
      end
   endtask

   task automatic rst_pulse;
      rst_m = 1'b0;
      @(negedge clk);
      rst_m = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      bit md, mdr;
      rst_m = 1'b0;
      rst_t = 1'b0;
      addr  = '0;
      data  = '0;
      wen   = 1'b0;
      mode  = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset(1'b0);
      chk_reset(1'b1);
      rst_m = 1'b1;
      @(negedge clk);

      plan_good(1'b0, 1, 1'b0, CN);
      run(1'b0, 1'b0, 1'b1);
      drain();
      // REPORT must ignore a re-arm attempt and later writes
      addr = TP;
      data = BSYM;
      wen  = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      @(negedge clk);
      repeat (3) begin
         data = 32'd77;
         wen  = 1'b1;
         @(negedge clk);
         wen = 1'b0;
         @(negedge clk);
      end
      chk("sticky.finish", fin_m, 1);
      chk("sticky.error_num", err_m, 0);
      chk("sticky.duration", dur_m, last_exp.dur);

      rst_pulse();
      plan_good(1'b1, 1, 1'b0, CN);
      run(1'b0, 1'b1, 1'b1);
      drain();

      rst_pulse();
      plan_good(1'b0, 1, 1'b0, CN);
      run(1'b0, 1'b1, 1'b1);
      drain();

      rst_pulse();
      plan_good(1'b0, 3, 1'b0, CN);
      pgl[10] = 1'b1;
      run(1'b0, 1'b0, 1'b1);
      drain();

      rst_pulse();
      plan_good(1'b0, 1, 1'b0, CN);
      pv[7]  = 32'd99;
      pv[20] = 32'd0;
      run(1'b0, 1'b0, 1'b1);
      drain();

      rst_m = 1'b0;
      rst_t = 1'b1;
      @(negedge clk);
      plan_good(1'b0, 1, 1'b0, 10);
      run(1'b1, 1'b0, 1'b1);
      drain();
      rst_t = 1'b0;

      rst_m = 1'b1;
      @(negedge clk);
      plan_good(1'b0, 1, 1'b0, 20);
      run(1'b0, 1'b0, 1'b0);
      #2 rst_m = 1'b0;
      #1 chk_reset(1'b0);
      @(negedge clk);
      rst_m = 1'b1;
      @(negedge clk);
      plan_good(1'b0, 1, 1'b0, CN);
      run(1'b0, 1'b0, 1'b1);
      drain();

      for (int r = 0; r < 8; r++) begin
         rst_pulse();
         md  = 1'($urandom);
         mdr = ($urandom_range(0, 3) == 0) ? !md : md;
         plan_good(md, 0, 1'b1, CN);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               pv[$urandom_range(0, CN - 1)] = 32'($urandom_range(0, 60));
            end
         end
         run(1'b0, mdr, 1'b1);
         drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
